// File: rtl/spi_pwm_array.sv
// spi_pwm_array: SPI mode-0 register file driving an array of PWM channels.
// 16-bit frames {rw, addr[6:0], data[7:0]}; writes commit on chip-select rise,
// reads return the addressed register on CIPO during the data byte.
// Optional macro PWM_DOUBLE_BUFFER_EN: duty writes land in a shadow register
// that is copied to the active duty when the PWM counter wraps to 0.
`timescale 1ns/1ps
module spi_pwm_array #(
  parameter int unsigned NUM_CH   = 16,
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned CLK_DIV  = 3000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_copi,
  output logic              spi_cipo,
  output logic              spi_cipo_oe,
  output logic [NUM_CH-1:0] pwm_out
);

  localparam int unsigned NB   = NUM_CH / 8;
  localparam int unsigned PS_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  // Synchronisers and edge-detect history
  logic [1:0] sclk_sync, cs_sync, copi_sync;
  logic       sclk_d, cs_d;
  logic       sclk_s, cs_s, copi_s;
  logic       sclk_rise, sclk_fall, cs_rise, cs_fall;

  // SPI shift state
  logic [4:0]  bit_cnt;
  logic [15:0] rx;
  logic [7:0]  tx;
  logic        tx_on;
  logic        rd_frame;
  logic [7:0]  rd_data;
  logic [31:0] ra, wa;
  logic        wr_en;

  // Register file
  logic [NUM_CH-1:0]   en_out, en_pwm;
  logic [PWM_BITS-1:0] duty [NUM_CH];
`ifdef PWM_DOUBLE_BUFFER_EN
  logic [PWM_BITS-1:0] duty_sh [NUM_CH];
`endif

  // Timebase
  logic [PS_W-1:0]     ps;
  logic [PWM_BITS-1:0] cnt;
  logic                tick, wrap_tick;

  // Two-stage synchronisers; cs_n idles high so reset leaves the bus deselected
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      copi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[0], spi_sclk};
      cs_sync   <= {cs_sync[0], spi_cs_n};
      copi_sync <= {copi_sync[0], spi_copi};
      sclk_d    <= sclk_sync[1];
      cs_d      <= cs_sync[1];
    end
  end

  assign sclk_s    = sclk_sync[1];
  assign cs_s      = cs_sync[1];
  assign copi_s    = copi_sync[1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign cs_fall   = ~cs_s & cs_d;

  assign spi_cipo_oe = ~cs_s;
  assign spi_cipo    = tx_on & tx[7];

  // Address of a read is complete once the 8th bit is on the synchronised COPI
  assign ra    = {25'd0, rx[5:0], copi_s};
  assign wa    = {25'd0, rx[14:8]};
  assign wr_en = cs_rise && (bit_cnt == 5'd16) && rx[15];

  // Frame receive and read shift-out; bit_cnt saturates at 17 so long frames never commit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt  <= '0;
      rx       <= '0;
      tx       <= '0;
      tx_on    <= 1'b0;
      rd_frame <= 1'b0;
    end else if (cs_fall) begin
      bit_cnt  <= '0;
      tx_on    <= 1'b0;
      rd_frame <= 1'b0;
    end else if (cs_rise) begin
      tx_on    <= 1'b0;
      rd_frame <= 1'b0;
    end else if (!cs_s) begin
      if (sclk_rise) begin
        rx <= {rx[14:0], copi_s};
        if (bit_cnt != 5'd17) bit_cnt <= bit_cnt + 5'd1;
        if ((bit_cnt == 5'd7) && !rx[6]) begin
          tx       <= rd_data;
          rd_frame <= 1'b1;
        end
      end else if (sclk_fall && rd_frame) begin
        // First fall after the load only exposes tx[7]; later falls shift
        if (!tx_on) tx_on <= 1'b1;
        else        tx    <= {tx[6:0], 1'b0};
      end
    end
  end

  // Readback multiplexer
  always_comb begin
    rd_data = '0;
    for (int unsigned k = 0; k < NB; k++) begin
      if (ra == k)      rd_data = en_out[8*k +: 8];
      if (ra == NB + k) rd_data = en_pwm[8*k +: 8];
    end
    for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
`ifdef PWM_DOUBLE_BUFFER_EN
      if (ra == 2*NB + ch) rd_data = 8'(duty_sh[ch]);
`else
      if (ra == 2*NB + ch) rd_data = 8'(duty[ch]);
`endif
    end
  end

  // Register writes (and active-duty reload when double buffered)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_out <= '0;
      en_pwm <= '0;
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
        duty[ch] <= '0;
`ifdef PWM_DOUBLE_BUFFER_EN
        duty_sh[ch] <= '0;
`endif
      end
    end else begin
      for (int unsigned k = 0; k < NB; k++) begin
        if (wr_en && (wa == k))      en_out[8*k +: 8] <= rx[7:0];
        if (wr_en && (wa == NB + k)) en_pwm[8*k +: 8] <= rx[7:0];
      end
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
`ifdef PWM_DOUBLE_BUFFER_EN
        if (wr_en && (wa == 2*NB + ch)) duty_sh[ch] <= rx[PWM_BITS-1:0];
        if (wrap_tick) duty[ch] <= duty_sh[ch];
`else
        if (wr_en && (wa == 2*NB + ch)) duty[ch] <= rx[PWM_BITS-1:0];
`endif
      end
    end
  end

  assign tick      = (ps == PS_W'(CLK_DIV - 1));
  assign wrap_tick = tick && (cnt == '1);

  // Prescaler and shared PWM counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ps  <= '0;
      cnt <= '0;
    end else if (tick) begin
      ps  <= '0;
      cnt <= cnt + PWM_BITS'(1);
    end else begin
      ps  <= ps + PS_W'(1);
    end
  end

  // Registered channel outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_out <= '0;
    end else begin
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
        pwm_out[ch] <= en_out[ch] &
                       (~en_pwm[ch] | (duty[ch] == '1) | (cnt < duty[ch]));
      end
    end
  end

endmodule

// File: tb/tb_spi_pwm_array.sv
// Scoreboard bench for spi_pwm_array: stimulus pushes expectations, monitors
// pop and compare when the DUT presents a read frame or a sampled output.
`timescale 1ns/1ps
module tb_spi_pwm_array;
  localparam int unsigned NUM_CH   = 16;
  localparam int unsigned PWM_BITS = 8;
  localparam int unsigned CLK_DIV  = 1;
  localparam int HALF   = 6;
  localparam int K_PWM  = 0;
  localparam int K_PIN  = 1;
  localparam int K_HCNT = 2;
  localparam int K_READ = 3;

  logic clk = 1'b0, rst_n = 1'b0;
  logic spi_sclk = 1'b0, spi_cs_n = 1'b1, spi_copi = 1'b0;
  logic spi_cipo, spi_cipo_oe;
  logic [NUM_CH-1:0] pwm_out;

  always #5 clk = ~clk;

  spi_pwm_array #(.NUM_CH(NUM_CH), .PWM_BITS(PWM_BITS), .CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
    .spi_copi(spi_copi), .spi_cipo(spi_cipo), .spi_cipo_oe(spi_cipo_oe),
    .pwm_out(pwm_out)
  );

  typedef struct { string name; int kind; logic [31:0] val; } exp_t;
  exp_t exp_q[$];
  int checks = 0, errors = 0;
  bit chk_pending = 1'b0;

  task automatic compare(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wclk(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(string nm, int kind, logic [31:0] v);
    exp_t e;
    e.name = nm; e.kind = kind; e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic expect_now(string nm, int kind, logic [31:0] v);
    push(nm, kind, v);
    chk_pending = 1'b1;
    wait (!chk_pending);
  endtask

  task automatic send_bit(logic b);
    spi_copi = b;
    wclk(HALF);
    spi_sclk = 1'b1;
    wclk(HALF);
    spi_sclk = 1'b0;
  endtask

  task automatic cs_start();
    spi_cs_n = 1'b0;
    wclk(HALF);
  endtask

  task automatic cs_end();
    wclk(HALF);
    spi_cs_n = 1'b1;
    wclk(2*HALF);
  endtask

  task automatic frame(logic [16:0] v, int n);
    cs_start();
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    cs_end();
  endtask

  task automatic wr(logic [6:0] a, logic [7:0] d);
    frame({1'b0, 1'b1, a, d}, 16);
  endtask

  task automatic rd(string nm, logic [6:0] a, logic [7:0] exp);
    push(nm, K_READ, {24'd0, exp});
    frame({1'b0, 1'b0, a, 8'h00}, 16);
  endtask

  // Sample monitor: serves pwm/pin/high-count expectations
  initial begin : sample_mon
    exp_t e;
    int hc;
    forever begin
      wait (chk_pending);
      if (exp_q.size() == 0) begin
        compare("sample_queue_empty", 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        case (e.kind)
          K_PWM: begin
            @(negedge clk);
            compare(e.name, 32'(pwm_out), e.val);
          end
          K_PIN: begin
            @(negedge clk);
            compare(e.name, {30'd0, spi_cipo_oe, spi_cipo}, e.val);
          end
          K_HCNT: begin
            hc = 0;
            repeat (256) begin
              @(negedge clk);
              if (pwm_out[3]) hc++;
            end
            compare(e.name, 32'(hc), e.val);
          end
          default: compare({e.name, "_kind"}, 32'(e.kind), 32'(K_PWM));
        endcase
      end
      chk_pending = 1'b0;
    end
  end

  // Read monitor: captures CIPO at each SCLK rise, checks complete read frames
  initial begin : read_mon
    exp_t e;
    int nb;
    bit done;
    logic [15:0] cap_cipo, cap_copi;
    forever begin
      @(negedge spi_cs_n);
      nb = 0; cap_cipo = '0; cap_copi = '0; done = 1'b0;
      while (!done) begin
        @(posedge spi_sclk or posedge spi_cs_n);
        if (spi_cs_n) begin
          done = 1'b1;
        end else begin
          cap_cipo = {cap_cipo[14:0], spi_cipo};
          cap_copi = {cap_copi[14:0], spi_copi};
          nb++;
        end
      end
      if (nb == 16 && !cap_copi[15]) begin
        if (exp_q.size() == 0) begin
          compare("read_queue_empty", 32'(cap_cipo), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          // Command byte period must show 0, data byte MSB first
          compare(e.name, 32'(cap_cipo), {16'd0, 8'h00, e.val[7:0]});
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    wclk(2);
    rst_n = 1'b1;
    wclk(2);
    expect_now("reset_pwm", K_PWM, 32'h0);
    expect_now("reset_pins", K_PIN, 32'h0);
    for (int a = 0; a < 20; a++) rd($sformatf("reset_rd_%0d", a), 7'(a), 8'h00);
    rd("reset_rd_7f", 7'h7F, 8'h00);

    // Static enables
    wr(7'd0, 8'hA5);
    wr(7'd1, 8'h01);
    expect_now("static_pwm", K_PWM, 32'h01A5);
    rd("rd_addr0", 7'd0, 8'hA5);
    rd("rd_addr1", 7'd1, 8'h01);

    // Malformed frames leave addr0 alone
    frame(17'h0407F, 15);
    frame({16'h80FF, 1'b1}, 17);
    rd("rd_after_bad_len", 7'd0, 8'hA5);
    expect_now("pwm_after_bad_len", K_PWM, 32'h01A5);
    frame(17'h00080, 8);
    wr(7'd0, 8'h5A);
    rd("rd_after_abort", 7'd0, 8'h5A);

    // Readback of a duty register and an unmapped address
    wr(7'h09, 8'h3C);
    rd("rd_duty5", 7'h09, 8'h3C);
    rd("rd_unmapped", 7'h7F, 8'h00);

    // PWM on channel 3
    wr(7'd0, 8'h08);
    wr(7'd1, 8'h00);
    wr(7'd2, 8'h08);
    wr(7'd7, 8'h40);
    wclk(300);
    expect_now("hcnt_duty40", K_HCNT, 32'd64);
    wr(7'd7, 8'hFF);
    wclk(300);
    expect_now("hcnt_dutyFF", K_HCNT, 32'd256);
    expect_now("pwm_dutyFF", K_PWM, 32'h0008);
    wr(7'd7, 8'h00);
    wclk(300);
    expect_now("hcnt_duty00", K_HCNT, 32'd0);

    // Reset during a write frame
    cs_start();
    for (int i = 15; i >= 6; i--) send_bit(1'(16'h8055 >> i));
    rst_n = 1'b0;
    wclk(2);
    spi_cs_n = 1'b1;
    spi_copi = 1'b0;
    wclk(2);
    rst_n = 1'b1;
    wclk(4);
    expect_now("midrst_pwm", K_PWM, 32'h0);
    expect_now("midrst_pins", K_PIN, 32'h0);
    rd("midrst_rd_addr0", 7'd0, 8'h00);

    wclk(4);
    compare("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
